secded_decode_pipe: RTL and testbench

- Parametrised, pipelined extended-Hamming SECDED decoder; the successor to the team's fixed 16/21 SEC-only decoder.
- Adds double-error detection via an overall parity bit, a valid/ready handshake with backpressure, a detect-only mode, per-word error status and saturating error counters.
- Sits on the receive side of the link, between the deserialiser and the data consumers.

---
 rtl/secded_pkg.sv | 42 ++++
 rtl/secded_decode_pipe_syndrome.sv | 20 ++
 rtl/secded_decode_pipe.sv | 176 +++++++++++++++++
 tb/tb_secded_decode_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared definitions for the extended-Hamming SECDED decode path.
package secded_pkg;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_SEC,
    ERR_PAR_ONLY,
    ERR_DED,
    ERR_INVALID
  } err_class_e;

  // Number of Hamming check bits: smallest p with 2^p >= data_width + p + 1.
  function automatic int unsigned calc_p(input int unsigned data_width);
    int unsigned p;
    p = 0;
    for (int unsigned i = 1; i < 31; i++) begin
      if (p == 0 && (32'd1 << i) >= data_width + i + 1) p = i;
    end
    return p;
  endfunction

  function automatic bit is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Hamming position (1-based) of payload bit 'index'; payload fills the
  // non-power-of-two positions LSB-first.
  function automatic int unsigned data_pos(input int unsigned index);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned k = 1; k < 1024; k++) begin
      if (!is_pow2(k)) begin
        if (cnt == index && pos == 0) pos = k;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_decode_pipe_syndrome.sv
// Combinational Hamming syndrome and overall-parity check of one codeword.
module secded_syndrome #(
  parameter int unsigned HAM_WIDTH = 21,
  parameter int unsigned P         = 5
) (
  input  logic [HAM_WIDTH:0] code_i,
  output logic [P-1:0]       syndrome_o,
  output logic               parity_err_o
);

  // Syndrome is the XOR of the positions of all set bits; parity over every bit.
  always_comb begin
    syndrome_o = '0;
    for (int unsigned k = 0; k < HAM_WIDTH; k++) begin
      if (code_i[k]) syndrome_o = syndrome_o ^ P'(k + 1);
    end
    parity_err_o = ^code_i;
  end

endmodule

// File: rtl/secded_decode_pipe.sv
// Two-stage pipelined SECDED decoder with valid/ready flow control,
// detect-only mode and saturating error counters.
module secded_decode_pipe
  import secded_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 16,
  parameter  int unsigned COUNT_WIDTH = 16,
  localparam int unsigned P           = calc_p(DATA_WIDTH),
  localparam int unsigned HAM_WIDTH   = DATA_WIDTH + P,
  localparam int unsigned ENC_WIDTH   = HAM_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ENC_WIDTH-1:0]   encoded_data,
  input  logic                   correct_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  decoded_data,
  output logic                   err_corrected,
  output logic                   err_uncorrectable,
  output logic [P-1:0]           err_syndrome,
  input  logic                   cnt_clr,
  output logic [COUNT_WIDTH-1:0] sec_count,
  output logic [COUNT_WIDTH-1:0] ded_count
);

  localparam logic [P-1:0] HAM_MAX = P'(HAM_WIDTH);

  logic [P-1:0]           syn_c;
  logic                   perr_c;
  logic [DATA_WIDTH-1:0]  raw_data;

  logic                   s1_valid_q, s1_valid_d;
  logic [P-1:0]           s1_syn_q;
  logic                   s1_perr_q;
  logic [DATA_WIDTH-1:0]  s1_data_q;
  logic                   s1_ce_q;

  logic                   s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0]  s2_data_q;
  logic                   s2_corr_q;
  logic                   s2_unc_q;
  logic [P-1:0]           s2_syn_q;

  logic [COUNT_WIDTH-1:0] sec_cnt_q, sec_cnt_d;
  logic [COUNT_WIDTH-1:0] ded_cnt_q, ded_cnt_d;

  err_class_e             s1_class;
  logic                   flip_en;
  logic                   corr_c;
  logic                   unc_c;
  logic [DATA_WIDTH-1:0]  fixed_data;

  logic                   s1_load;
  logic                   s2_load;
  logic                   out_hs;

  secded_syndrome #(
    .HAM_WIDTH (HAM_WIDTH),
    .P         (P)
  ) u_syndrome (
    .code_i       (encoded_data),
    .syndrome_o   (syn_c),
    .parity_err_o (perr_c)
  );

  // S1 keeps only the payload bits of the raw word: the check bits are fully
  // summarised by the registered syndrome and parity result.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    localparam int unsigned POS = data_pos(i);
    assign raw_data[i]   = encoded_data[POS-1];
    assign fixed_data[i] = s1_data_q[i] ^ (flip_en && (s1_syn_q == P'(POS)));
  end

  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;
  assign out_hs   = s2_valid_q && out_ready;

  // Classify the S1 word from syndrome and overall parity.
  always_comb begin
    if (s1_syn_q == '0) begin
      s1_class = s1_perr_q ? ERR_PAR_ONLY : ERR_NONE;
    end else if (!s1_perr_q) begin
      s1_class = ERR_DED;
    end else if (s1_syn_q > HAM_MAX) begin
      s1_class = ERR_INVALID;
    end else begin
      s1_class = ERR_SEC;
    end
    flip_en = s1_ce_q && (s1_class == ERR_SEC);
    corr_c  = (s1_class == ERR_SEC) || (s1_class == ERR_PAR_ONLY);
    unc_c   = (s1_class == ERR_DED) || (s1_class == ERR_INVALID);
  end

  // Next-state for stage valid bits and saturating counters (clear wins).
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_load)      s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (s2_load)        s2_valid_d = 1'b1;
    else if (out_ready) s2_valid_d = 1'b0;

    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (cnt_clr) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (out_hs) begin
      if (s2_corr_q && sec_cnt_q != '1) sec_cnt_d = sec_cnt_q + COUNT_WIDTH'(1);
      if (s2_unc_q && ded_cnt_q != '1)  ded_cnt_d = ded_cnt_q + COUNT_WIDTH'(1);
    end
  end

  // Stage 1: capture syndrome, parity result, payload and mode on input handshake.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_valid_q <= 1'b0;
      s1_syn_q   <= '0;
      s1_perr_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_ce_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_syn_q  <= syn_c;
        s1_perr_q <= perr_c;
        s1_data_q <= raw_data;
        s1_ce_q   <= correct_en;
      end
    end
  end

  // Stage 2: capture corrected payload and status; holds while stalled.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_corr_q  <= 1'b0;
      s2_unc_q   <= 1'b0;
      s2_syn_q   <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_data_q <= fixed_data;
        s2_corr_q <= corr_c;
        s2_unc_q  <= unc_c;
        s2_syn_q  <= s1_syn_q;
      end
    end
  end

  // Error counters.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign out_valid         = s2_valid_q;
  assign decoded_data      = s2_data_q;
  assign err_corrected     = s2_corr_q;
  assign err_uncorrectable = s2_unc_q;
  assign err_syndrome      = s2_syn_q;
  assign sec_count         = sec_cnt_q;
  assign ded_count         = ded_cnt_q;

endmodule

// File: tb/tb_secded_decode_pipe.sv
// Scoreboard bench for secded_decode_pipe: directed codewords with
// hand-computed payload/flags; a second instance has 2-bit counters.
module tb_secded_decode_pipe;

  localparam int DW = 16;
  localparam int EW = 22;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          in_valid = 1'b0;
  logic          correct_en = 1'b1;
  logic          out_ready = 1'b1;
  logic          cnt_clr = 1'b0;
  logic [EW-1:0] encoded_data = '0;

  logic          in_ready, out_valid, err_corrected, err_uncorrectable;
  logic [DW-1:0] decoded_data;
  logic [PW-1:0] err_syndrome;
  logic [15:0]   sec_count, ded_count;

  logic          in_ready2, out_valid2, err_corrected2, err_uncorrectable2;
  logic [DW-1:0] decoded_data2;
  logic [PW-1:0] err_syndrome2;
  logic [1:0]    sec_count2, ded_count2;

  secded_decode_pipe #(.DATA_WIDTH(16), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready),
    .encoded_data(encoded_data), .correct_en(correct_en),
    .out_valid(out_valid), .out_ready(out_ready), .decoded_data(decoded_data),
    .err_corrected(err_corrected), .err_uncorrectable(err_uncorrectable),
    .err_syndrome(err_syndrome), .cnt_clr(cnt_clr),
    .sec_count(sec_count), .ded_count(ded_count)
  );

  secded_decode_pipe #(.DATA_WIDTH(16), .COUNT_WIDTH(2)) dut2 (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready2),
    .encoded_data(encoded_data), .correct_en(correct_en),
    .out_valid(out_valid2), .out_ready(out_ready), .decoded_data(decoded_data2),
    .err_corrected(err_corrected2), .err_uncorrectable(err_uncorrectable2),
    .err_syndrome(err_syndrome2), .cnt_clr(cnt_clr),
    .sec_count(sec_count2), .ded_count(ded_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          corr;
    logic          unc;
    logic [PW-1:0] syn;
    int            acc;
  } exp_t;

  typedef struct {
    logic [EW-1:0] word;
    logic          ce;
    exp_t          exp;
  } vec_t;

  vec_t  vecs[12];
  exp_t  q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    sec_m = 0, ded_m = 0, sec_m2 = 0, ded_m2 = 0;
  bit    mon_en = 1'b0;
  bit    lat_chk = 1'b0;
  bit    stalled = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setv(input int idx, input logic [EW-1:0] w, input logic ce,
                      input logic [DW-1:0] d, input logic c, input logic u,
                      input logic [PW-1:0] s);
    vecs[idx].word     = w;
    vecs[idx].ce       = ce;
    vecs[idx].exp.data = d;
    vecs[idx].exp.corr = c;
    vecs[idx].exp.unc  = u;
    vecs[idx].exp.syn  = s;
    vecs[idx].exp.acc  = -1;
  endtask

  task automatic send(input int idx);
    bit   done;
    exp_t e;
    done = 1'b0;
    @(negedge clk);
    in_valid     = 1'b1;
    encoded_data = vecs[idx].word;
    correct_en   = vecs[idx].ce;
    for (int t = 0; t < 50 && !done; t++) begin
      #1;
      if (in_ready) begin
        e     = vecs[idx].exp;
        e.acc = lat_chk ? cyc : -1;
        q.push_back(e);
        done  = 1'b1;
      end
      @(posedge clk);
      if (!done) @(negedge clk);
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: vector %0d never accepted", idx);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 60) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("drain_queue_empty", q.size(), 0);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Monitor: compares presented output against the queue head every cycle
  // (held words are re-checked), pops on handshake, tracks counter model.
  initial begin : monitor
    exp_t e;
    bit   hs;
    forever begin
      @(negedge clk);
      #2;
      if (rstb && mon_en) begin
        check("sec_count", sec_count, sec_m);
        check("ded_count", ded_count, ded_m);
        check("sec_count_w2", sec_count2, sec_m2);
        check("ded_count_w2", ded_count2, ded_m2);
        hs = 1'b0;
        if (out_valid) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_out: out_valid with empty scoreboard, data=%0d", decoded_data);
          end else begin
            e = q[0];
            check("decoded_data", decoded_data, e.data);
            check("err_corrected", err_corrected, e.corr);
            check("err_uncorrectable", err_uncorrectable, e.unc);
            check("err_syndrome", err_syndrome, e.syn);
            if (e.acc >= 0) check("latency", cyc - e.acc, 2);
            if (out_valid2) begin
              check("decoded_data_w2", decoded_data2, e.data);
              check("err_corrected_w2", err_corrected2, e.corr);
              check("err_uncorrectable_w2", err_uncorrectable2, e.unc);
              check("err_syndrome_w2", err_syndrome2, e.syn);
            end
            if (out_ready) begin
              void'(q.pop_front());
              hs = 1'b1;
            end
          end
        end
        if (cnt_clr) begin
          sec_m = 0; ded_m = 0; sec_m2 = 0; ded_m2 = 0;
        end else if (hs) begin
          if (e.corr) begin
            sec_m  = sat(sec_m + 1, 65535);
            sec_m2 = sat(sec_m2 + 1, 3);
          end
          if (e.unc) begin
            ded_m  = sat(ded_m + 1, 65535);
            ded_m2 = sat(ded_m2 + 1, 3);
          end
        end
      end
    end
  end

  initial begin : stim
    int t;
    int bp_list[8];
    //   idx word      ce   data   corr unc syn
    setv(0,  22'd2097234, 1'b1, 16'd10,    1'b0, 1'b0, 5'd0);
    setv(1,  22'd599040,  1'b1, 16'd19008, 1'b0, 1'b0, 5'd0);
    setv(2,  22'd1433996, 1'b1, 16'd44561, 1'b0, 1'b0, 5'd0);
    setv(3,  22'd599168,  1'b1, 16'd19008, 1'b1, 1'b0, 5'd8);   // check bit at pos 8
    setv(4,  22'd1433868, 1'b1, 16'd44561, 1'b1, 1'b0, 5'd8);
    setv(5,  22'd2696192, 1'b1, 16'd19008, 1'b1, 1'b0, 5'd0);   // overall bit only
    setv(6,  22'd599232,  1'b1, 16'd19016, 1'b0, 1'b1, 5'd15);  // pos 7,8: raw payload
    setv(7,  22'd599168,  1'b0, 16'd19008, 1'b1, 1'b0, 5'd8);   // detect-only, check bit
    setv(8,  22'd598016,  1'b0, 16'd18944, 1'b1, 1'b0, 5'd11);  // detect-only, data bit
    setv(9,  22'd598016,  1'b1, 16'd19008, 1'b1, 1'b0, 5'd11);  // same word corrected
    setv(10, 22'd32897,   1'b1, 16'd0,     1'b0, 1'b1, 5'd25);  // syndrome beyond pos 21
    setv(11, 22'd0,       1'b1, 16'd0,     1'b0, 1'b0, 5'd0);
    bp_list = '{0, 1, 2, 3, 5, 6, 9, 11};

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_decoded_data", decoded_data, 0);
    check("rst_err_corrected", err_corrected, 0);
    check("rst_err_uncorrectable", err_uncorrectable, 0);
    check("rst_err_syndrome", err_syndrome, 0);
    check("rst_sec_count", sec_count, 0);
    check("rst_ded_count", ded_count, 0);
    @(negedge clk);
    rstb = 1'b1;
    #1;
    check("in_ready_after_release", in_ready, 1);
    mon_en = 1'b1;

    // Clean words back-to-back with latency checked
    lat_chk = 1'b1;
    send(0); send(1); send(2);
    idle();
    drain();
    lat_chk = 1'b0;

    // Single, overall-bit, double, detect-only and invalid-position words
    for (int i = 3; i < 12; i++) send(i);
    idle();
    drain();
    check("sec_after_errors", sec_count, 6);
    check("ded_after_errors", ded_count, 2);
    check("sec_saturated_w2", sec_count2, 3);

    // Backpressure: out_ready low for cycles 3..7 of the burst
    fork
      begin
        for (int i = 0; i < 8; i++) send(bp_list[i]);
        idle();
      end
      begin
        for (int c = 0; c < 14; c++) begin
          @(negedge clk);
          out_ready = !(c >= 3 && c <= 7);
        end
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          #1;
          if (in_valid && !in_ready) stalled = 1'b1;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("in_ready_fell_under_stall", stalled, 1);

    // Clear coincident with a flagged output handshake
    @(negedge clk);
    out_ready = 1'b0;
    send(3);
    idle();
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("clr_word_presented", out_valid, 1);
    @(negedge clk);
    cnt_clr   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #3;
    check("sec_after_clr", sec_count, 0);
    check("ded_after_clr", ded_count, 0);
    check("sec_after_clr_w2", sec_count2, 0);
    drain();

    // Reset mid-stream drops in-flight words
    send(1);
    send(2);
    #3;
    check("pre_reset_out_valid", out_valid, 1);
    rstb     = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_reset_out_valid", out_valid, 0);
    check("mid_reset_in_ready", in_ready, 1);
    q.delete();
    sec_m = 0; ded_m = 0; sec_m2 = 0; ded_m2 = 0;
    repeat (2) @(negedge clk);
    check("mid_reset_decoded_data", decoded_data, 0);
    check("mid_reset_sec_count", sec_count, 0);
    rstb = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1);
    send(4);
    idle();
    drain();
    check("sec_after_reset_word", sec_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
